apu_reg_writer: RTL

// - Register-write front end for the APU channels: turns a serial byte stream
//   (address byte, then data byte) into the 16 registers $4000-$400F.
// - Emits a one-cycle write event per register, so channels reload their

---
 rtl/apu_reg_writer_pkg.sv | 18 +
 rtl/apu_reg_writer.sv | 97 +++++++++
 2 files changed

// File: rtl/apu_reg_writer_pkg.sv
// Shared definitions for the APU register-write front end: FSM encoding,
// address-flag bit position and the noise-channel register offsets.
package apu_reg_writer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_e;

    // Bit of an incoming byte that marks it as an address byte (in IDLE only)
    localparam int ADDR_FLAG = 7;

    // Register offsets from $4000 used by the noise channel
    localparam int REG_400C = 12;
    localparam int REG_400E = 14;
    localparam int REG_400F = 15;

endpackage

// File: rtl/apu_reg_writer.sv
// Turns a serial {address, data} byte stream into the APU register file
// $4000.. with a one-cycle write event per register and an error pulse.
module apu_reg_writer
    import apu_reg_writer_pkg::*;
#(
    parameter int NUM_REGS       = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [8*NUM_REGS-1:0]   reg_bank,
    output logic [NUM_REGS-1:0]     reg_event,
    output logic                    err
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e                     state_q, state_d;
    logic [6:0]                 addr_q, addr_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [NUM_REGS-1:0][7:0]   bank_q, bank_d;
    logic [NUM_REGS-1:0]        event_q, event_d;
    logic                       err_q, err_d;
    logic                       addr_ok;

    assign addr_ok = ({1'b0, addr_q} < 8'(NUM_REGS));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        timer_d = timer_q;
        bank_d  = bank_q;
        event_d = '0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data[ADDR_FLAG]) begin
                        addr_d  = rx_data[6:0];
                        timer_d = '0;
                        state_d = ST_DATA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                // A byte arriving on the expiry cycle still counts as data
                if (rx_valid) begin
                    state_d = ST_IDLE;
                    if (addr_ok) begin
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (addr_q == 7'(k)) begin
                                bank_d[k]  = rx_data;
                                event_d[k] = 1'b1;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            timer_q <= '0;
            bank_q  <= '0;
            event_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            bank_q  <= bank_d;
            event_q <= event_d;
            err_q   <= err_d;
        end
    end

    assign reg_bank  = bank_q;
    assign reg_event = event_q;
    assign err       = err_q;

endmodule
